// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready stage register with two-entry skid and flush; PIPE_STALL_CNT_EN adds stall_cycles
module pipe_stage_skid #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter logic [CTRL_W-1:0] NOP_CTRL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);
  localparam logic [1:0] EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2;
  logic [1:0] state, state_nxt;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic in_fire, out_fire, load_main_in, load_main_skid, load_skid;
  always_comb begin
    in_ready = state != FULL;
    out_valid = state != EMPTY;
    in_fire = in_valid & in_ready;
    out_fire = out_valid & out_ready;
    load_main_in = !flush & in_fire & ((state == EMPTY) | out_fire);
    load_skid = !flush & in_fire & (state == ONE) & !out_fire;
    load_main_skid = !flush & out_fire & (state == FULL);
    state_nxt = flush ? EMPTY :
                state == EMPTY ? (in_fire ? ONE : EMPTY) :
                state == ONE ? (in_fire == out_fire ? ONE : in_fire ? FULL : EMPTY) :
                (out_fire ? ONE : FULL);
    out_ctrl = out_valid ? main_ctrl : NOP_CTRL;
    out_data = main_data;
    occupancy = state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      state <= state_nxt;
      if (load_main_in) begin
        main_ctrl <= in_ctrl;
        main_data <= in_data;
      end else if (load_main_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end
      if (load_skid) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end
    end
  end
`ifdef PIPE_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) stall_cycles <= '0;
    else if (out_valid & !out_ready & !flush & ~&stall_cycles) stall_cycles <= stall_cycles + 32'd1;
  end
`endif
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: table vectors plus scoreboard for pipe_stage_skid
module tb_pipe_stage_skid;
  typedef struct {
    logic iv;
    logic [7:0] ic;
    logic [31:0] id;
    logic ordy;
    logic fl;
    logic ir;
    logic ov;
    logic [1:0] occ;
  } vec_t;
  logic clk = 1'b0, rst, flush, in_valid, out_ready;
  logic [7:0] in_ctrl;
  logic [31:0] in_data;
  logic in_ready, out_valid, in_ready1, out_valid1;
  logic [7:0] out_ctrl, out_ctrl1;
  logic [31:0] out_data, out_data1;
  logic [1:0] occupancy, occupancy1;
`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stall_cycles, stall_cycles1, s0;
`endif
  logic [39:0] sb[$];
  vec_t tv[$];
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  pipe_stage_skid u0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .occupancy(occupancy)
`ifdef PIPE_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );
  pipe_stage_skid #(.NOP_CTRL(8'h13)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
    .out_ctrl(out_ctrl1), .out_data(out_data1), .occupancy(occupancy1)
`ifdef PIPE_STALL_CNT_EN
    , .stall_cycles(stall_cycles1)
`endif
  );
  function automatic vec_t mk(logic iv, logic [7:0] ic, logic [31:0] id, logic ordy, logic fl,
                              logic ir, logic ov, logic [1:0] occ);
    vec_t v;
    v.iv = iv; v.ic = ic; v.id = id; v.ordy = ordy; v.fl = fl;
    v.ir = ir; v.ov = ov; v.occ = occ;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic cyc(input logic iv, input logic [7:0] ic, input logic [31:0] id, input logic ordy, input logic fl);
    logic [39:0] e;
    in_valid = iv; in_ctrl = ic; in_data = id; out_ready = ordy; flush = fl;
    #1;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_underflow: got beat %0h expected none", {out_ctrl, out_data});
      end else begin
        e = sb.pop_front();
        chk("out_beat", {out_ctrl, out_data}, e);
        chk("out_beat_u1", {out_ctrl1, out_data1}, e);
      end
    end
    if (in_valid && in_ready && !fl) sb.push_back({ic, id});
    if (fl) sb.delete();
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int k = 1; k <= 8; k++) tv.push_back(mk(1'b1, 8'h11, k, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1));
    tv.push_back(mk(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0));
    tv.push_back(mk(1'b1, 8'hAB, 32'hA, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1));
    tv.push_back(mk(1'b1, 8'hAB, 32'hB, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2));
    tv.push_back(mk(1'b1, 8'hAB, 32'hC, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2));
    tv.push_back(mk(1'b1, 8'hAB, 32'hC, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1));
    tv.push_back(mk(1'b1, 8'hAB, 32'hC, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1));
    tv.push_back(mk(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0));
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_ctrl = 8'hFF; in_data = 32'hDEAD_BEEF; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_occupancy", occupancy, 0);
`ifdef PIPE_STALL_CNT_EN
    chk("rst_stall", stall_cycles, 0);
`endif
    rst = 1'b0; in_valid = 1'b0;
    foreach (tv[i]) begin
      cyc(tv[i].iv, tv[i].ic, tv[i].id, tv[i].ordy, tv[i].fl);
      chk($sformatf("v%0d_in_ready", i), in_ready, tv[i].ir);
      chk($sformatf("v%0d_out_valid", i), out_valid, tv[i].ov);
      chk($sformatf("v%0d_occupancy", i), occupancy, tv[i].occ);
      if (!tv[i].ov) begin
        chk($sformatf("v%0d_nop0", i), out_ctrl, 8'h00);
        chk($sformatf("v%0d_nop13", i), out_ctrl1, 8'h13);
      end
    end
    cyc(1'b1, 8'h33, 32'h5, 1'b0, 1'b0);
    chk("sim_hold5", out_data, 32'h5);
    cyc(1'b1, 8'h33, 32'h6, 1'b1, 1'b0);
    chk("sim_data6", out_data, 32'h6);
    chk("sim_occ1", occupancy, 1);
    cyc(1'b0, 8'h00, 32'h0, 1'b1, 1'b0);
    chk("sim_drain_occ", occupancy, 0);
    cyc(1'b1, 8'h5A, 32'h21, 1'b0, 1'b0);
    cyc(1'b1, 8'h5A, 32'h22, 1'b0, 1'b0);
    chk("fl_pre_occ", occupancy, 2);
    chk("fl_pre_in_ready", in_ready, 0);
    cyc(1'b1, 8'h5A, 32'h23, 1'b0, 1'b1);
    chk("fl_out_valid", out_valid1, 0);
    chk("fl_out_ctrl", out_ctrl1, 8'h13);
    chk("fl_occ", occupancy1, 0);
    chk("fl_in_ready", in_ready1, 1);
    chk("fl_data_kept", out_data, 32'h21);
    cyc(1'b0, 8'h00, 32'h0, 1'b1, 1'b0);
    chk("fl_no_ghost", out_valid, 0);
    chk("fl_no_ghost_occ", occupancy, 0);
    chk("sb_drained", sb.size(), 0);
`ifdef PIPE_STALL_CNT_EN
    cyc(1'b1, 8'h44, 32'h77, 1'b0, 1'b0);
    s0 = stall_cycles;
    repeat (5) cyc(1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
    chk("stall_5", stall_cycles - s0, 5);
    cyc(1'b0, 8'h00, 32'h0, 1'b0, 1'b1);
    chk("stall_flush", stall_cycles - s0, 5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("stall_rst", stall_cycles, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
